thor2022_ptg_cache: RTL
=======================

THOR2022_PTG_CACHE -- requirements
Module: thor2022_ptg_cache

Interface
REQ-001 Parameter DEP, 8, number of cache entries; power of two, 2..16.
REQ-002 Parameter AW, 32, physical address width in bits.
REQ-003 Port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  synchronous, active-high reset, sampled on rising clk_i.
REQ-005 Port lk_req_i  input  1  lookup request strobe; one lookup per cycle, no backpressure.
REQ-006 Port lk_adr_i  input  AW  byte address of the page table group (PTG) being looked up.
REQ-007 Port lk_ack_o  output  1  one-cycle pulse marking a valid lookup result.
REQ-008 Port lk_hit_o  output  1  lookup hit flag, qualified by lk_ack_o.
REQ-009 Port lk_ptg_o  output  1024  PTG data of the hit entry (8 x 128-bit hash PTEs); zero on a miss.
REQ-010 Port fill_i  input  1  write a PTG fetched by the walker from memory.
REQ-011 Port fill_adr_i  input  AW  address of the filled PTG.
REQ-012 Port fill_ptg_i  input  1024  PTG data being filled.
REQ-013 Port inv_i  input  1  invalidate the entry matching inv_adr_i.
REQ-014 Port inv_adr_i  input  AW  address to invalidate.
REQ-015 Port inv_all_i  input  1  invalidate all entries.

Function
REQ-016 Each entry holds v, tag = adr[AW-1:7] (a PTG is 128 bytes, so bits [6:0] are ignored everywhere), and 1024 data bits.
REQ-017 Address match is v AND tag equal to bits [AW-1:7] of the presented address.
REQ-018 Lookup latency is exactly 1 cycle: lk_req_i at edge N gives lk_ack_o=1 with lk_hit_o and lk_ptg_o at N+1; lk_ack_o=0 in any cycle not following a request.
REQ-019 Back-to-back requests are fully pipelined; every request gets exactly one ack, in order.
REQ-020 On a miss, lk_hit_o=0 and lk_ptg_o=0; outputs are registered and hold until the next ack.
REQ-021 A lookup sees the contents present before that edge; a fill, inv or inv_all in the same cycle is not visible to it.
REQ-022 Fill with an existing match overwrites that entry's data in place; the replacement pointer is unchanged.
REQ-023 Fill without a match writes the entry at the replacement pointer (v=1), and the pointer increments modulo DEP (DEP-1 wraps to 0).
REQ-024 Invalid entries are not preferred; replacement is strict round-robin.
REQ-025 Every tag is held by at most one valid entry at all times; multiple hits cannot occur.
REQ-026 inv_i clears v of the matching entry; a miss has no effect; pointer unchanged.
REQ-027 inv_all_i clears v of every entry; data and pointer are unchanged.
REQ-028 Same-cycle priority is inv_all_i, then inv_i, then fill_i; a fill suppressed by inv_all_i, or by inv_i to the same tag, writes nothing and does not advance the pointer.
REQ-029 A fill and an inv_i to different tags in the same cycle both take effect.

Reset
REQ-030 With rst_i high, all v=0, pointer=0, and lk_ack_o, lk_hit_o and lk_ptg_o read 0 at the next edge.
REQ-031 A request sampled in the same cycle as rst_i is dropped (no ack); a request pending when reset asserts produces no ack.
REQ-032 Fill, inv and lookup inputs are ignored while rst_i is high; normal operation begins on the first edge after rst_i deasserts.

Verification
REQ-033 After reset, lookup 0x1000 -> lk_ack_o=1 next cycle, lk_hit_o=0, lk_ptg_o=0.
REQ-034 Fill 0x1000 with pattern A; lookup 0x1040 next cycle -> hit, lk_ptg_o=A; the same-cycle fill+lookup of 0x2000 -> miss.
REQ-035 Fill 9 distinct tags 0x0000..0x0400 (step 0x80) -> 0x0000 misses, 0x0080..0x0400 hit, and the pointer is 1.
REQ-036 Refill 0x0100 with B -> hit returns B, pointer unchanged, no duplicate entry (scan all tags for a single hit).
REQ-037 Same-cycle fill 0x3000 and inv 0x3000 -> subsequent lookup misses and pointer unchanged; inv_all then lookup of any prior tag -> miss.
REQ-038 Continuous lk_req_i for 20 cycles with rst_i pulsed at cycle 10 -> 20 requests issued, acks only for non-reset cycles in order, all misses after reset.

Source files
------------

// File: rtl/thor2022_ptg_cache.sv
// Fully associative page-table-group cache: one-cycle registered lookup,
// in-place refill on hit, round-robin replacement on miss, single/global invalidate.
module thor2022_ptg_cache #(
  parameter int unsigned DEP = 8,
  parameter int unsigned AW  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lk_req_i,
  input  logic [AW-1:0]     lk_adr_i,
  output logic              lk_ack_o,
  output logic              lk_hit_o,
  output logic [1023:0]     lk_ptg_o,
  input  logic              fill_i,
  input  logic [AW-1:0]     fill_adr_i,
  input  logic [1023:0]     fill_ptg_i,
  input  logic              inv_i,
  input  logic [AW-1:0]     inv_adr_i,
  input  logic              inv_all_i
);

  localparam int unsigned TW = AW - 7;
  localparam int unsigned PW = (DEP > 1) ? $clog2(DEP) : 1;
  localparam int unsigned DW = 1024;

  logic [DEP-1:0] v;
  logic [TW-1:0]  tag  [DEP];
  logic [DW-1:0]  data [DEP];
  logic [PW-1:0]  ptr;

  logic [TW-1:0]  lk_tag_c, fill_tag_c, inv_tag_c;
  logic [DEP-1:0] lk_match_c, fill_match_c, inv_match_c, fill_wr_c;
  logic           lk_hit_c, fill_hit_c, fill_en_c;
  logic [DW-1:0]  lk_data_c;
  logic [PW-1:0]  ptr_nxt_c;

  assign lk_tag_c   = lk_adr_i[AW-1:7];
  assign fill_tag_c = fill_adr_i[AW-1:7];
  assign inv_tag_c  = inv_adr_i[AW-1:7];

  // Tag compare against the contents held before this edge
  always_comb begin
    lk_match_c   = '0;
    fill_match_c = '0;
    inv_match_c  = '0;
    lk_data_c    = '0;
    for (int unsigned i = 0; i < DEP; i++) begin
      lk_match_c[i]   = v[i] && (tag[i] == lk_tag_c);
      fill_match_c[i] = v[i] && (tag[i] == fill_tag_c);
      inv_match_c[i]  = v[i] && (tag[i] == inv_tag_c) && inv_i;
      if (lk_match_c[i]) lk_data_c = lk_data_c | data[i];
    end
    lk_hit_c   = |lk_match_c;
    fill_hit_c = |fill_match_c;
  end

  // A fill loses to inv_all and to an invalidate of its own tag
  always_comb begin
    fill_en_c = fill_i && !inv_all_i && !(inv_i && (inv_tag_c == fill_tag_c));
    ptr_nxt_c = (ptr == PW'(DEP - 1)) ? '0 : ptr + PW'(1);
    fill_wr_c = '0;
    for (int unsigned i = 0; i < DEP; i++) begin
      if (fill_en_c) fill_wr_c[i] = fill_hit_c ? fill_match_c[i] : (ptr == PW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v   <= '0;
      ptr <= '0;
    end else if (inv_all_i) begin
      v <= '0;
    end else begin
      v <= (v & ~inv_match_c) | fill_wr_c;
      if (fill_en_c && !fill_hit_c) ptr <= ptr_nxt_c;
    end
  end

  // Tag and data storage is not reset; validity alone gates use
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEP; i++) begin
      if (!rst_i && fill_wr_c[i]) begin
        tag[i]  <= fill_tag_c;
        data[i] <= fill_ptg_i;
      end
    end
  end

  // Result registers hold their value until the next ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lk_ack_o <= 1'b0;
      lk_hit_o <= 1'b0;
      lk_ptg_o <= '0;
    end else begin
      lk_ack_o <= lk_req_i;
      if (lk_req_i) begin
        lk_hit_o <= lk_hit_c;
        lk_ptg_o <= lk_data_c;
      end
    end
  end

endmodule
